// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared definitions for the Pong match controller.
//   - state_t : match sequencer state encoding (IDLE..GAME_OVER)
//   - SC_*    : PS/2 scan-code constants (break prefix, extended prefix,
//               space = start key, P = pause key)
//   - sat_inc : saturating score increment
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_PAUSE,
    ST_GAME_OVER
  } state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_P      = 8'h4D;

  function automatic logic [2:0] sat_inc(input logic [2:0] s, input logic [2:0] lim);
    return (s >= lim) ? lim : s + 3'd1;
  endfunction

endpackage

// File: rtl/pong_key_decoder.sv
// pong_key_decoder
//   Turns the raw PS/2 byte stream into start/pause key strobes.
//   A break prefix (F0) swallows the following byte (key release), the
//   extended prefix (E0) is dropped. Strobes are combinational and only as
//   wide as ps2_valid, so the sequencer acts on them exactly once.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ps2_valid          new byte strobe
//   ps2_data[7:0]      scan-code byte
//   start_key          make code of KEY_START seen this cycle
//   pause_key          make code of KEY_PAUSE seen this cycle
module pong_key_decoder
  import pong_pkg::*;
#(
  parameter logic [7:0] KEY_START = SC_SPACE,
  parameter logic [7:0] KEY_PAUSE = SC_P
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  output logic       start_key,
  output logic       pause_key
);

  logic break_reg;
  logic make_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      break_reg <= 1'b0;
    end else if (ps2_valid) begin
      if (break_reg)
        break_reg <= 1'b0;             // released key code consumed
      else if (ps2_data == SC_BREAK)
        break_reg <= 1'b1;
    end
  end

  assign make_valid = ps2_valid && !break_reg &&
                      (ps2_data != SC_BREAK) && (ps2_data != SC_EXTEND);
  assign start_key  = make_valid && (ps2_data == KEY_START);
  assign pause_key  = make_valid && (ps2_data == KEY_PAUSE);

endmodule

// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer
//   Match controller for the Pong datapath: IDLE -> SERVE -> PLAY -> POINT
//   -> (SERVE | GAME_OVER), with PAUSE reachable from SERVE and PLAY.
//   One down-counter times both the serve delay and the point hold; it is
//   frozen while paused so a resumed serve continues where it stopped.
//   All outputs are registered and follow their cause by one cycle.
// Optional feature
//   PONG_AUDIO_EN : when defined, audio_beep is high for 8 frame ticks after
//                   each accepted point; otherwise audio_beep is tied low.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   frame_tick               one strobe per video frame (delay time base)
//   ps2_valid, ps2_data      PS/2 scan-code byte stream
//   point_p1, point_p2       scoring strobes from the datapath
//   stand                    1 = datapath frozen
//   start_pulse              reset_to_start pulse
//   checkpoint_pulse         reset_to_checkpoint pulse
//   score_p1, score_p2       scores 0..WIN_SCORE
//   game_over, winner        match finished / who won (0 = player 1)
//   paused                   1 while paused
//   audio_beep               point tone
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int         WIN_SCORE         = 6,
  parameter int         SERVE_DELAY_TICKS = 120,
  parameter int         POINT_HOLD_TICKS  = 60,
  parameter logic [7:0] KEY_START         = SC_SPACE,
  parameter logic [7:0] KEY_PAUSE         = SC_P
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_data,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       stand,
  output logic       start_pulse,
  output logic       checkpoint_pulse,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic       paused,
  output logic       audio_beep
);

  localparam int MAX_DELAY = (SERVE_DELAY_TICKS > POINT_HOLD_TICKS) ?
                             SERVE_DELAY_TICKS : POINT_HOLD_TICKS;
  localparam int TW = $clog2(MAX_DELAY + 1);
  localparam logic [TW-1:0] SERVE_LOAD = TW'(SERVE_DELAY_TICKS);
  localparam logic [TW-1:0] POINT_LOAD = TW'(POINT_HOLD_TICKS);
  localparam logic [2:0]    WIN        = 3'(WIN_SCORE);

  logic start_key, pause_key;

  pong_key_decoder #(
    .KEY_START (KEY_START),
    .KEY_PAUSE (KEY_PAUSE)
  ) u_key_decoder (
    .clk       (clk),
    .rst       (rst),
    .ps2_valid (ps2_valid),
    .ps2_data  (ps2_data),
    .start_key (start_key),
    .pause_key (pause_key)
  );

  state_t        state_reg, state_next;
  state_t        saved_reg, saved_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    score_p1_reg, score_p1_next;
  logic [2:0]    score_p2_reg, score_p2_next;
  logic          winner_reg, winner_next;
  logic          start_next, checkpoint_next;
  logic          stand_reg, start_pulse_reg, checkpoint_pulse_reg;
  logic          game_over_reg, paused_reg;
  logic          point_accept;

  always_comb begin
    state_next      = state_reg;
    saved_next      = saved_reg;
    timer_next      = timer_reg;
    score_p1_next   = score_p1_reg;
    score_p2_next   = score_p2_reg;
    winner_next     = winner_reg;
    start_next      = 1'b0;
    checkpoint_next = 1'b0;
    point_accept    = 1'b0;

    case (state_reg)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_key) begin
          state_next    = ST_SERVE;
          timer_next    = SERVE_LOAD;
          score_p1_next = 3'd0;
          score_p2_next = 3'd0;
          start_next    = 1'b1;
        end
      end

      ST_SERVE: begin
        if (pause_key) begin
          saved_next = ST_SERVE;
          state_next = ST_PAUSE;
        end else if (frame_tick) begin
          // Last tick of the delay moves straight on instead of sitting at 0.
          if (timer_reg <= TW'(1)) begin
            timer_next = '0;
            state_next = ST_PLAY;
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
      end

      ST_PLAY: begin
        // Player 1 wins a simultaneous strobe; any point beats a key.
        if (point_p1 || point_p2) begin
          point_accept = 1'b1;
          state_next   = ST_POINT;
          timer_next   = POINT_LOAD;
          if (point_p1) score_p1_next = sat_inc(score_p1_reg, WIN);
          else          score_p2_next = sat_inc(score_p2_reg, WIN);
        end else if (pause_key) begin
          saved_next = ST_PLAY;
          state_next = ST_PAUSE;
        end
      end

      ST_POINT: begin
        if (frame_tick) begin
          if (timer_reg <= TW'(1)) begin
            if (score_p1_reg == WIN || score_p2_reg == WIN) begin
              timer_next  = '0;
              state_next  = ST_GAME_OVER;
              winner_next = (score_p2_reg == WIN);
            end else begin
              timer_next      = SERVE_LOAD;
              state_next      = ST_SERVE;
              checkpoint_next = 1'b1;
            end
          end else begin
            timer_next = timer_reg - TW'(1);
          end
        end
      end

      ST_PAUSE: begin
        if (pause_key) state_next = saved_reg;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= ST_IDLE;
      saved_reg            <= ST_IDLE;
      timer_reg            <= '0;
      score_p1_reg         <= 3'd0;
      score_p2_reg         <= 3'd0;
      winner_reg           <= 1'b0;
      stand_reg            <= 1'b1;
      start_pulse_reg      <= 1'b0;
      checkpoint_pulse_reg <= 1'b0;
      game_over_reg        <= 1'b0;
      paused_reg           <= 1'b0;
    end else begin
      state_reg            <= state_next;
      saved_reg            <= saved_next;
      timer_reg            <= timer_next;
      score_p1_reg         <= score_p1_next;
      score_p2_reg         <= score_p2_next;
      winner_reg           <= winner_next;
      stand_reg            <= (state_next != ST_PLAY);
      start_pulse_reg      <= start_next;
      checkpoint_pulse_reg <= checkpoint_next;
      game_over_reg        <= (state_next == ST_GAME_OVER);
      paused_reg           <= (state_next == ST_PAUSE);
    end
  end

  assign stand            = stand_reg;
  assign start_pulse      = start_pulse_reg;
  assign checkpoint_pulse = checkpoint_pulse_reg;
  assign score_p1         = score_p1_reg;
  assign score_p2         = score_p2_reg;
  assign game_over        = game_over_reg;
  assign winner           = winner_reg;
  assign paused           = paused_reg;

`ifdef PONG_AUDIO_EN
  logic [3:0] beep_cnt_reg, beep_cnt_next;
  logic       audio_beep_reg;

  // Each accepted point reloads the full 8-tick tone.
  always_comb begin
    beep_cnt_next = beep_cnt_reg;
    if (point_accept)
      beep_cnt_next = 4'd8;
    else if (frame_tick && beep_cnt_reg != 4'd0)
      beep_cnt_next = beep_cnt_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beep_cnt_reg   <= 4'd0;
      audio_beep_reg <= 1'b0;
    end else begin
      beep_cnt_reg   <= beep_cnt_next;
      audio_beep_reg <= (beep_cnt_next != 4'd0);
    end
  end

  assign audio_beep = audio_beep_reg;
`else
  logic audio_unused;
  assign audio_unused = point_accept;
  assign audio_beep   = 1'b0;
`endif

endmodule

// File: tb/tb_pong_match_sequencer.sv
module tb_pong_match_sequencer;

  localparam int SERVE_T = 120;
  localparam int POINT_T = 60;
  localparam int WIN     = 6;
  // {stand, start, checkpoint, s1[3], s2[3], game_over, winner, paused, beep}
  localparam logic [12:0] RESET_VEC = 13'b1_0_0_000_000_0_0_0_0;
`ifdef PONG_AUDIO_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, frame_tick, ps2_valid, point_p1, point_p2;
  logic [7:0] ps2_data;
  logic       stand, start_pulse, checkpoint_pulse, game_over, winner, paused, audio_beep;
  logic [2:0] score_p1, score_p2;

  always #5 clk = ~clk;

  pong_match_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .frame_tick       (frame_tick),
    .ps2_valid        (ps2_valid),
    .ps2_data         (ps2_data),
    .point_p1         (point_p1),
    .point_p2         (point_p2),
    .stand            (stand),
    .start_pulse      (start_pulse),
    .checkpoint_pulse (checkpoint_pulse),
    .score_p1         (score_p1),
    .score_p2         (score_p2),
    .game_over        (game_over),
    .winner           (winner),
    .paused           (paused),
    .audio_beep       (audio_beep)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
  endtask

  // Reference model: match described as a named mode plus "ticks left".
  string m_mode, m_saved;
  int    m_left, m_s1, m_s2, m_beep;
  bit    m_brk, m_start, m_chk, m_win;

  task automatic model_step(input bit r, input bit t, input bit v, input logic [7:0] d,
                            input bit a, input bit b);
    bit sk, pk, scored;
    if (r) begin
      m_mode = "IDLE"; m_saved = "IDLE"; m_left = 0; m_s1 = 0; m_s2 = 0; m_beep = 0;
      m_brk = 0; m_start = 0; m_chk = 0; m_win = 0;
      return;
    end
    sk = 0; pk = 0; scored = 0;
    if (v) begin
      if (m_brk) m_brk = 0;
      else if (d == 8'hF0) m_brk = 1;
      else if (d == 8'h29) sk = 1;
      else if (d == 8'h4D) pk = 1;
    end
    m_start = 0; m_chk = 0;
    if (m_mode == "IDLE" || m_mode == "GAME_OVER") begin
      if (sk) begin
        m_mode = "SERVE"; m_left = SERVE_T; m_s1 = 0; m_s2 = 0; m_start = 1;
      end
    end else if (m_mode == "PAUSE") begin
      if (pk) m_mode = m_saved;
    end else if (m_mode == "PLAY" && (a || b)) begin
      if (a) m_s1 = (m_s1 < WIN) ? m_s1 + 1 : WIN;
      else   m_s2 = (m_s2 < WIN) ? m_s2 + 1 : WIN;
      m_mode = "POINT"; m_left = POINT_T; scored = 1;
    end else if (pk && (m_mode == "PLAY" || m_mode == "SERVE")) begin
      m_saved = m_mode; m_mode = "PAUSE";
    end else if (t && (m_mode == "SERVE" || m_mode == "POINT")) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == "SERVE") m_mode = "PLAY";
        else if (m_s1 == WIN || m_s2 == WIN) begin
          m_mode = "GAME_OVER"; m_win = (m_s2 == WIN);
        end else begin
          m_mode = "SERVE"; m_left = SERVE_T; m_chk = 1;
        end
      end
    end
    if (scored) m_beep = 8;
    else if (t && m_beep > 0) m_beep--;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [12:0] e;
    e = {m_mode != "PLAY", m_start, m_chk, 3'(m_s1), 3'(m_s2), m_mode == "GAME_OVER",
         m_win, m_mode == "PAUSE", BEEP_ON && (m_beep > 0)};
    return e;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {stand, start_pulse, checkpoint_pulse, score_p1, score_p2, game_over,
            winner, paused, audio_beep};
  endfunction

  task automatic step(input bit r, input bit t, input bit v, input logic [7:0] d,
                      input bit a, input bit b);
    rst = r; frame_tick = t; ps2_valid = v; ps2_data = d; point_p1 = a; point_p2 = b;
    @(posedge clk);
    model_step(r, t, v, d, a, b);
    #1;
    check("cycle", 32'(dut_vec()), 32'(exp_vec()));
    if (r || v || a || b)
      $display("tx t=%0t rst=%0b key=%0b/%h pts=%0b%0b -> mode=%s s=%0d:%0d",
               $time, r, v, d, a, b, m_mode, m_s1, m_s2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 8'h00, 0, 0);
  endtask

  task automatic key(input logic [7:0] d);
    step(0, 0, 1, d, 0, 0);
  endtask

  task automatic pt(input bit a, input bit b);
    step(0, 0, 0, 8'h00, a, b);
  endtask

  initial begin
    // 1: start and serve delay
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    check("reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
    key(8'h29);
    check("t1_start_pulse", 32'(start_pulse), 32'd1);
    check("t1_stand_serve", 32'(stand), 32'd1);
    ticks(SERVE_T - 1);
    check("t1_stand_before_end", 32'(stand), 32'd1);
    ticks(1);
    check("t1_stand_play", 32'(stand), 32'd0);

    // 2: point, hold, checkpoint, serve
    pt(1, 0);
    check("t2_score_p1", 32'(score_p1), 32'd1);
    check("t2_stand_point", 32'(stand), 32'd1);
    ticks(POINT_T);
    check("t2_checkpoint", 32'(checkpoint_pulse), 32'd1);
    ticks(SERVE_T);
    check("t2_stand_play", 32'(stand), 32'd0);

    // 3: break code ignored, pause/resume
    step(1, 0, 0, 8'h00, 0, 0);
    key(8'hF0);
    key(8'h29);
    check("t3_break_ignored", 32'({stand, start_pulse}), 32'b10);
    key(8'h29);
    ticks(SERVE_T);
    key(8'h4D);
    check("t3_paused", 32'(paused), 32'd1);
    ticks(50);
    key(8'h4D);
    check("t3_resumed", 32'({paused, stand}), 32'b00);

    // 4: simultaneous strobes, then player 2 wins
    pt(1, 1);
    check("t4_tie_p1", 32'(score_p1), 32'd1);
    check("t4_tie_p2", 32'(score_p2), 32'd0);
    ticks(POINT_T + SERVE_T);
    for (int k = 0; k < WIN; k++) begin
      pt(0, 1);
      ticks(POINT_T);
      if (k < WIN - 1) ticks(SERVE_T);
    end
    check("t4_game_over", 32'(game_over), 32'd1);
    check("t4_winner", 32'(winner), 32'd1);
    check("t4_score_p2", 32'(score_p2), 32'd6);
    pt(1, 0);
    check("t4_point_ignored", 32'(score_p1), 32'd1);

    // 5: reset mid-point hold
    key(8'h29);
    ticks(SERVE_T);
    pt(1, 0);
    ticks(20);
    step(1, 0, 0, 8'h00, 0, 0);
    check("t5_reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
    key(8'h29);
    check("t5_fresh", 32'({start_pulse, score_p1, score_p2}), 32'b1_000_000);

    // 6: tone length
    ticks(SERVE_T);
    pt(0, 1);
    check("t6_beep_start", 32'(audio_beep), 32'(BEEP_ON));
    for (int i = 1; i <= 8; i++) begin
      ticks(1);
      check("t6_beep_tick", 32'(audio_beep), 32'(BEEP_ON && i < 8));
    end

    // Random play against the model
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        step(1, 0, 0, 8'h00, 0, 0);
      end else if (r < 600) begin
        ticks(1);
      end else if (r < 700 || r >= 950) begin
        logic [7:0] d;
        case ($urandom_range(0, 5))
          0: d = 8'h29;
          1: d = 8'hF0;
          2: d = 8'hE0;
          3: d = 8'($urandom);
          default: d = 8'h4D;
        endcase
        if (r < 700) key(d);
        else step(0, 0, 0, 8'h00, 0, 0);
      end else if (r < 750) begin
        int w;
        bit withkey;
        w = $urandom_range(0, 2);
        withkey = ($urandom_range(0, 2) == 0);
        step(0, 0, withkey, 8'h4D, (w != 1), (w != 0));
      end else begin
        step(0, 0, 0, 8'h00, 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
